// File: rtl/dca_mru_step_sequencer.sv
// Round-robin front end for the MRU step port: grants one of two requesters, expands the
// command into last-flagged step instructions, then waits for done. First step 1 cycle after grant; steps hold under step_ready=0.
module dca_mru_step_sequencer #(
  parameter int BW_OPCODE     = 4,
  parameter int BW_STEP_COUNT = 8
) (
  input  logic                     clk,
  input  logic                     rstnn,
  input  logic                     req0_valid,
  input  logic [BW_OPCODE-1:0]     req0_opcode,
  input  logic [BW_STEP_COUNT-1:0] req0_count,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [BW_OPCODE-1:0]     req1_opcode,
  input  logic [BW_STEP_COUNT-1:0] req1_count,
  output logic                     req1_ready,
  output logic                     rsp0_valid,
  output logic                     rsp1_valid,
  output logic                     step_valid,
  output logic [BW_OPCODE:0]       step_inst,
  input  logic                     step_ready,
  input  logic                     step_done,
  output logic                     busy,
  output logic                     owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic                     rr_ptr;
  logic [BW_STEP_COUNT-1:0] remaining;
  logic [BW_OPCODE-1:0]     opcode_q;
  logic                     owner_q;

  logic grant0;
  logic grant1;
  logic take0;
  logic take1;
  logic step_fire;
  logic last_step;

  // rr_ptr names the requester that wins when both are valid
  assign grant0    = req0_valid & (~req1_valid | ~rr_ptr);
  assign grant1    = req1_valid & (~req0_valid | rr_ptr);
  assign take0     = (state == IDLE) & grant0;
  assign take1     = (state == IDLE) & grant1;
  assign step_fire = (state == ISSUE) & step_ready;
  assign last_step = (remaining == BW_STEP_COUNT'(1));

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (take0) begin
          state_nxt = (req0_count == '0) ? RESP : ISSUE;
        end else if (take1) begin
          state_nxt = (req1_count == '0) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (step_fire && last_step) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (step_done) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = take0;
    req1_ready = take1;
    step_valid = (state == ISSUE);
    step_inst  = {last_step, opcode_q};
    rsp0_valid = (state == RESP) & ~owner_q;
    rsp1_valid = (state == RESP) & owner_q;
    busy       = (state != IDLE);
    owner      = owner_q;
  end

  // remaining is only decremented in ISSUE, where it is always at least 1
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      rr_ptr    <= 1'b0;
      remaining <= '0;
      opcode_q  <= '0;
      owner_q   <= 1'b0;
    end else if (take0) begin
      rr_ptr    <= 1'b1;
      remaining <= req0_count;
      opcode_q  <= req0_opcode;
      owner_q   <= 1'b0;
    end else if (take1) begin
      rr_ptr    <= 1'b0;
      remaining <= req1_count;
      opcode_q  <= req1_opcode;
      owner_q   <= 1'b1;
    end else if (step_fire) begin
      remaining <= remaining - BW_STEP_COUNT'(1);
    end
  end

endmodule

// File: tb/tb_dca_mru_step_sequencer.sv
// Directed bench for dca_mru_step_sequencer: a command-level model is compared every cycle,
// and literal expectations pin step streams, grant order and response counts per scenario.
module tb_dca_mru_step_sequencer;

  logic       clk = 1'b0;
  logic       rstnn;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_opcode, req1_opcode;
  logic [7:0] req0_count, req1_count;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp1_valid;
  logic       step_valid;
  logic [4:0] step_inst;
  logic       step_ready, step_done;
  logic       busy, owner;

  int checks   = 0;
  int failures = 0;

  dca_mru_step_sequencer #(.BW_OPCODE(4), .BW_STEP_COUNT(8)) dut (
    .clk(clk), .rstnn(rstnn),
    .req0_valid(req0_valid), .req0_opcode(req0_opcode), .req0_count(req0_count), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_opcode(req1_opcode), .req1_count(req1_count), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .step_valid(step_valid), .step_inst(step_inst), .step_ready(step_ready), .step_done(step_done),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Command-level model: an active command has some steps left to issue, then waits for
  // done, then spends one cycle responding.
  bit       m_active, m_waiting, m_resp, m_owner, m_next;
  int       m_left;
  bit [3:0] m_op;

  always @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      m_active = 0; m_waiting = 0; m_resp = 0; m_owner = 0; m_next = 0; m_left = 0; m_op = 0;
    end else if (!m_active) begin
      if (req0_valid && (!req1_valid || m_next == 0)) begin
        m_active = 1; m_owner = 0; m_next = 1; m_op = req0_opcode; m_left = req0_count;
        m_resp = (req0_count == 0);
      end else if (req1_valid) begin
        m_active = 1; m_owner = 1; m_next = 0; m_op = req1_opcode; m_left = req1_count;
        m_resp = (req1_count == 0);
      end
    end else if (m_resp) begin
      m_active = 0; m_resp = 0;
    end else if (m_left > 0) begin
      if (step_ready) begin
        m_left--;
        if (m_left == 0) m_waiting = 1;
      end
    end else if (m_waiting && step_done) begin
      m_waiting = 0; m_resp = 1;
    end
  end

  logic [4:0] acc_q[$];
  int         gnt_q[$];
  int         rsp_q[$];
  int         rsp0_cnt = 0, rsp1_cnt = 0, sv_cnt = 0;

  always @(negedge clk) begin
    logic e_rdy0, e_rdy1, e_sv;
    e_rdy0 = !m_active && req0_valid && (!req1_valid || m_next == 0);
    e_rdy1 = !m_active && req1_valid && (!req0_valid || m_next == 1);
    e_sv   = m_active && m_left > 0;
    check("req0_ready", req0_ready, e_rdy0);
    check("req1_ready", req1_ready, e_rdy1);
    check("step_valid", step_valid, e_sv);
    if (e_sv) check("step_inst", step_inst, {m_left == 1, m_op});
    check("rsp0_valid", rsp0_valid, m_resp && !m_owner);
    check("rsp1_valid", rsp1_valid, m_resp && m_owner);
    check("busy", busy, m_active);
    check("owner", owner, m_owner);
    if (step_valid && step_ready) acc_q.push_back(step_inst);
    if (step_valid) sv_cnt++;
    if (req0_valid && req0_ready) gnt_q.push_back(0);
    if (req1_valid && req1_ready) gnt_q.push_back(1);
    if (rsp0_valid) begin rsp0_cnt++; rsp_q.push_back(0); end
    if (rsp1_valid) begin rsp1_cnt++; rsp_q.push_back(1); end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int r0, r1, sv0;

  initial begin
    rstnn = 0; req0_valid = 0; req1_valid = 0; req0_opcode = 0; req1_opcode = 0;
    req0_count = 0; req1_count = 0; step_ready = 0; step_done = 0;
    cyc(2);
    check("reset_busy", busy, 0);
    check("reset_step_valid", step_valid, 0);
    check("reset_owner", owner, 0);
    rstnn = 1;
    cyc(1);

    // Single command, three steps
    acc_q.delete(); r0 = rsp0_cnt;
    req0_valid = 1; req0_opcode = 4'h3; req0_count = 8'd3; step_ready = 1;
    cyc(1); req0_valid = 0;
    cyc(7);
    step_done = 1; cyc(1); step_done = 0; cyc(1);
    check("t1_nsteps", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      check("t1_step0", acc_q[0], 5'h03);
      check("t1_step1", acc_q[1], 5'h03);
      check("t1_step2", acc_q[2], 5'h13);
    end
    check("t1_rsp0", rsp0_cnt - r0, 1);
    check("t1_idle", busy, 0);

    // Backpressure
    acc_q.delete();
    req0_valid = 1; req0_opcode = 4'h5; req0_count = 8'd2; step_ready = 0;
    cyc(1); req0_valid = 0;
    for (int i = 0; i < 8; i++) begin step_ready = i[0]; cyc(1); end
    step_ready = 0; step_done = 1; cyc(1); step_done = 0; cyc(2);
    check("bp_nsteps", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      check("bp_step0", acc_q[0], 5'h05);
      check("bp_step1", acc_q[1], 5'h15);
    end

    // Round-robin from reset
    rstnn = 0; cyc(1); rstnn = 1; cyc(1);
    gnt_q.delete(); rsp_q.delete();
    req0_valid = 1; req0_opcode = 4'h1; req0_count = 8'd1;
    req1_valid = 1; req1_opcode = 4'h2; req1_count = 8'd1;
    step_ready = 1; step_done = 1;
    for (int i = 0; i < 60 && gnt_q.size() < 4; i++) cyc(1);
    check("rr_timeout", gnt_q.size() >= 4, 1);
    req0_valid = 0; req1_valid = 0;
    cyc(6); step_done = 0;
    check("rr_ngrants", gnt_q.size(), 4);
    check("rr_nrsp", rsp_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < gnt_q.size()) check("rr_grant", gnt_q[i], i % 2);
      if (i < rsp_q.size()) check("rr_rsp", rsp_q[i], i % 2);
    end

    // Zero count
    sv0 = sv_cnt; r1 = rsp1_cnt;
    req1_valid = 1; req1_opcode = 4'h7; req1_count = 8'd0;
    cyc(1); req1_valid = 0; cyc(3);
    check("zc_no_steps", sv_cnt - sv0, 0);
    check("zc_rsp1", rsp1_cnt - r1, 1);

    // Stray done in IDLE and ISSUE
    r0 = rsp0_cnt; r1 = rsp1_cnt; acc_q.delete();
    step_done = 1; cyc(2); step_done = 0;
    check("sd_idle", busy, 0);
    req0_valid = 1; req0_opcode = 4'h9; req0_count = 8'd3; step_ready = 0;
    cyc(1); req0_valid = 0; cyc(1);
    step_done = 1; cyc(1); step_done = 0;
    check("sd_issue_busy", busy, 1);
    check("sd_issue_sv", step_valid, 1);
    check("sd_no_rsp", (rsp0_cnt - r0) + (rsp1_cnt - r1), 0);
    step_ready = 1; cyc(3);
    step_done = 1; cyc(1); step_done = 0; cyc(2);
    check("sd_nsteps", acc_q.size(), 3);
    check("sd_rsp0", rsp0_cnt - r0, 1);

    // Reset during WAIT_DONE
    req0_valid = 1; req0_opcode = 4'h4; req0_count = 8'd1; step_ready = 1;
    cyc(1); req0_valid = 0; cyc(1);
    check("rm_waiting", busy, 1);
    r0 = rsp0_cnt; r1 = rsp1_cnt;
    rstnn = 0; #1;
    check("rm_busy", busy, 0);
    check("rm_outs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, step_valid, step_inst, owner}, 0);
    cyc(1); rstnn = 1; step_done = 1; cyc(2); step_done = 0;
    check("rm_no_rsp", (rsp0_cnt - r0) + (rsp1_cnt - r1), 0);
    gnt_q.delete();
    req0_valid = 1; req1_valid = 1; req1_count = 8'd1;
    cyc(1); req0_valid = 0; req1_valid = 0;
    check("rm_ngrant", gnt_q.size(), 1);
    if (gnt_q.size() > 0) check("rm_prio", gnt_q[0], 0);
    cyc(2); step_done = 1; cyc(1); step_done = 0; cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dca_mru_step_sequencer.md
Name: dca_mru_step_sequencer

Overview:
- Front-end scheduler for the DCA matrix register unit (MRU) step port.
- Arbitrates between two command requesters (e.g. the control-register path and a DMA/LSU command path) using round-robin.
- Expands the winning command (opcode, step count) into a stream of blocked-step instructions. The final instruction carries the last flag.
- Holds ownership until the MRU signals completion, then returns a one-cycle response to the owning requester.

Parameters:
- BW_OPCODE, 4: width of the MRU opcode field in a step instruction.
- BW_STEP_COUNT, 8: width of the per-command step count.

Ports:
- clk  input  1  clock; all logic on the rising edge
- rstnn  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 command valid
- req0_opcode  input  BW_OPCODE  requester 0 MRU opcode
- req0_count  input  BW_STEP_COUNT  requester 0 number of steps
- req0_ready  output  1  requester 0 command accepted this cycle
- req1_valid, req1_opcode, req1_count, req1_ready: same as requester 0, for requester 1
- rsp0_valid  output  1  one-cycle completion pulse for requester 0
- rsp1_valid  output  1  one-cycle completion pulse for requester 1
- step_valid  output  1  step instruction valid toward the MRU
- step_inst  output  BW_OPCODE+1  {last, opcode}; last is the MSB
- step_ready  input  1  MRU accepts the step instruction
- step_done  input  1  MRU pulse: last step drained and complete
- busy  output  1  high in every state except IDLE
- owner  output  1  index of the requester being served; valid while busy

Behaviour:
- Clock and reset: one clock, clk. Reset rstnn is asynchronous and active-low.
- Reset values: state=IDLE, rr pointer=0 (req0 has priority), remaining=0, latched opcode=0, owner=0.
- Output reset values: every output is 0.
- Reset asserted mid-operation aborts immediately. No response pulse is produced for the aborted command.
- FSM states: IDLE, ISSUE, WAIT_DONE, RESP.
- IDLE, grant:
  - Grant is combinational. Only the winner sees reqN_ready=1, and only in IDLE.
  - Both requesters valid: the grant goes to the rr pointer's requester.
  - One requester valid: the grant goes to that requester.
- IDLE, on handshake (reqN_valid & reqN_ready):
  - Latch opcode and count into remaining; set owner=N.
  - Set the rr pointer to ~N.
  - If count==0, go to RESP without issuing any step. Otherwise go to ISSUE.
- ISSUE:
  - step_valid=1.
  - step_inst={remaining==1, latched opcode}.
  - step_inst is held stable while step_ready=0.
  - On step_valid & step_ready: remaining decrements by 1.
  - If the accepted step had last=1, go to WAIT_DONE. step_valid drops in the following cycle.
- WAIT_DONE:
  - step_valid=0.
  - On step_done=1, go to RESP.
  - step_done is ignored in every other state. The MRU cannot assert done in the same cycle as the last-step handshake.
- RESP: lasts one cycle.
  - rsp<owner>_valid=1, then go to IDLE.
  - No req_ready is asserted in RESP.
  - The earliest new grant is in the cycle after RESP.
- Latency:
  - Command to first step_valid: 1 cycle.
  - step_done to rsp pulse: 1 cycle.
  - rsp pulse to next grant: 1 cycle.
- Width and wrap rules:
  - remaining is BW_STEP_COUNT bits and never underflows, because decrement occurs only when remaining ≥ 1.
  - count = 2^BW_STEP_COUNT−1 is legal and issues that many steps.
- Signal relations:
  - busy = (state != IDLE).
  - rsp0_valid and rsp1_valid are never high together.
  - reqN_ready is never high while busy.

Test Plan:
- Single command: req0 opcode=0x3, count=3, step_ready=1 → step_inst 0x03, 0x03, 0x13 on consecutive cycles. Then step_done after 4 idle cycles → rsp0_valid pulse 1 cycle later, then busy=0.
- Backpressure: count=2, step_ready toggles 0/1 each cycle → each step_inst is held stable while stalled. Exactly 2 steps are accepted, and last=1 only on the second.
- Round-robin: req0 and req1 held valid continuously, count=1 each, prompt step_done → grants alternate 0,1,0,1 starting with req0 after reset. Each rsp goes only to the owner.
- Zero count: req1 count=0 → no step_valid; rsp1_valid asserted the cycle after acceptance.
- Stray done: step_done pulsed in IDLE and during ISSUE → no state change and no rsp pulse.
- Reset mid-operation: rstnn low during WAIT_DONE → all outputs 0 immediately. After release, req0 has priority and no rsp pulse is produced for the aborted command.
